// File: rtl/button_event_capture.sv
// button_event_capture
//   Carries the on-board push buttons to the host over a Wire Out. Each
//   active-low button is synchronized and debounced. Press and release
//   events are latched as pending flags, and a small 4-bit press counter
//   is kept per button. The host acknowledges events through a Wire In.
//   Everything runs in the okClk domain.
//
// Ports
//   okClk       : sole clock (host interface clock)
//   reset       : synchronous, active-high
//   btn_n       : raw asynchronous buttons, active-low
//   ack_wire    : [3:0] clear press_pending, [7:4] clear release_pending,
//                 [11:8] clear overflow, [31] clear all press counters.
//                 Each bit acts on its rising edge.
//   status_wire : [3:0] debounced level, [7:4] press_pending,
//                 [11:8] release_pending, [15:12] overflow,
//                 [31:16] press counters (button i at [16+4i +: 4])
module button_event_capture #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 100800,
  parameter int CNT_W           = 17,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             okClk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [31:0]      ack_wire,
  output logic [31:0]      status_wire
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_r;
  logic [N_BTN-1:0]                  pressed_sync_s;
  logic [N_BTN-1:0]                  stable_r;
  logic [N_BTN-1:0]                  stable_nxt_s;
  logic [N_BTN-1:0][CNT_W-1:0]       db_cnt_r;
  logic [N_BTN-1:0][CNT_W-1:0]       db_cnt_nxt_s;
  logic [N_BTN-1:0]                  press_evt_s;
  logic [N_BTN-1:0]                  rel_evt_s;

  logic [N_BTN-1:0]                  press_pend_r;
  logic [N_BTN-1:0]                  press_pend_nxt_s;
  logic [N_BTN-1:0]                  rel_pend_r;
  logic [N_BTN-1:0]                  rel_pend_nxt_s;
  logic [N_BTN-1:0]                  ovf_r;
  logic [N_BTN-1:0]                  ovf_nxt_s;
  logic [N_BTN-1:0][3:0]             press_cnt_r;
  logic [N_BTN-1:0][3:0]             press_cnt_nxt_s;

  logic [31:0]                       ack_prev_r;
  logic [31:0]                       ack_rise_s;
  logic [31:0]                       status_r;
  logic [31:0]                       status_nxt_s;
  logic                              unused_ack_s;

  assign pressed_sync_s = ~sync_r[SYNC_STAGES-1];
  assign ack_rise_s     = ack_wire & ~ack_prev_r;
  // Ack bits with no function are folded away.
  assign unused_ack_s   = &{1'b0, ack_rise_s[30:12]};
  assign status_wire    = status_r;

  // Debounce: a mismatch must hold DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stable_nxt_s = stable_r;
    db_cnt_nxt_s = db_cnt_r;
    for (int i = 0; i < N_BTN; i++) begin
      if (pressed_sync_s[i] == stable_r[i]) begin
        db_cnt_nxt_s[i] = '0;
      end else if (db_cnt_r[i] == DB_LAST) begin
        stable_nxt_s[i] = pressed_sync_s[i];
        db_cnt_nxt_s[i] = '0;
      end else begin
        db_cnt_nxt_s[i] = db_cnt_r[i] + DB_ONE;
      end
    end
    press_evt_s = stable_nxt_s & ~stable_r;
    rel_evt_s   = stable_r & ~stable_nxt_s;
  end

  // Event flags and press counters; a set always wins over a same-cycle clear.
  always_comb begin
    press_pend_nxt_s = press_pend_r;
    rel_pend_nxt_s   = rel_pend_r;
    ovf_nxt_s        = ovf_r;
    press_cnt_nxt_s  = press_cnt_r;
    for (int i = 0; i < N_BTN; i++) begin
      press_pend_nxt_s[i] = press_evt_s[i] | (press_pend_r[i] & ~ack_rise_s[i]);
      rel_pend_nxt_s[i]   = rel_evt_s[i] | (rel_pend_r[i] & ~ack_rise_s[4+i]);
      // Overflow only when the old pending press survives this cycle.
      ovf_nxt_s[i]        = (press_evt_s[i] & press_pend_r[i] & ~ack_rise_s[i])
                          | (ovf_r[i] & ~ack_rise_s[8+i]);
      if (ack_rise_s[31]) begin
        press_cnt_nxt_s[i] = 4'd0;
      end else begin
        press_cnt_nxt_s[i] = press_cnt_r[i];
      end
      if (press_evt_s[i]) begin
        press_cnt_nxt_s[i] = press_cnt_nxt_s[i] + 4'd1;
      end else begin
        press_cnt_nxt_s[i] = press_cnt_nxt_s[i];
      end
    end
  end

  // Status image built from registered state; unused button lanes read 0.
  always_comb begin
    status_nxt_s = 32'h0000_0000;
    for (int i = 0; i < N_BTN; i++) begin
      status_nxt_s[i]            = stable_r[i];
      status_nxt_s[4+i]          = press_pend_r[i];
      status_nxt_s[8+i]          = rel_pend_r[i];
      status_nxt_s[12+i]         = ovf_r[i];
      status_nxt_s[16+4*i +: 4]  = press_cnt_r[i];
    end
  end

  // State registers, synchronous reset to the released/idle state.
  always_ff @(posedge okClk) begin
    if (reset) begin
      sync_r       <= '1;
      stable_r     <= '0;
      db_cnt_r     <= '0;
      press_pend_r <= '0;
      rel_pend_r   <= '0;
      ovf_r        <= '0;
      press_cnt_r  <= '0;
      ack_prev_r   <= 32'hFFFF_FFFF;
      status_r     <= 32'h0000_0000;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], btn_n};
      stable_r     <= stable_nxt_s;
      db_cnt_r     <= db_cnt_nxt_s;
      press_pend_r <= press_pend_nxt_s;
      rel_pend_r   <= rel_pend_nxt_s;
      ovf_r        <= ovf_nxt_s;
      press_cnt_r  <= press_cnt_nxt_s;
      ack_prev_r   <= ack_wire;
      status_r     <= status_nxt_s;
    end
  end

endmodule

// File: tb/tb_button_event_capture.sv
module tb_button_event_capture;

  logic        okClk;
  logic        reset;
  logic [3:0]  btn_n;
  logic [31:0] ack_wire;
  logic [31:0] status_wire;

  int n_cmp;
  int n_err;

  button_event_capture #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4),
    .SYNC_STAGES(2)
  ) dut (
    .okClk(okClk),
    .reset(reset),
    .btn_n(btn_n),
    .ack_wire(ack_wire),
    .status_wire(status_wire)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge okClk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges (counting the first sampling edge as 1) until status bit goes to val.
  task automatic wait_bit(input int b, input logic val, output int k);
    k = 31;
    for (int j = 1; j <= 30; j++) begin
      @(posedge okClk);
      #1;
      if (status_wire[b] === val) begin
        k = j;
        break;
      end
    end
  endtask

  task automatic press_release(input int b);
    btn_n[b] = 1'b0;
    tick(12);
    btn_n[b] = 1'b1;
    tick(12);
  endtask

  initial begin
    int k;
    logic [31:0] seen;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    btn_n    = 4'hF;
    ack_wire = 32'h0;

    // 1: reset and idle
    tick(3);
    reset = 1'b0;
    chk("reset_status", status_wire, 32'h0000_0000);
    seen = 32'h0;
    for (int j = 0; j < 100; j++) begin
      tick(1);
      seen = seen | status_wire;
    end
    chk("idle_100", seen, 32'h0000_0000);

    // 2: press latency, release latency
    btn_n[0] = 1'b0;
    wait_bit(0, 1'b1, k);
    chk("press_latency", 32'(k), 32'd11);
    chk("press_status", status_wire, 32'h0001_0011);
    tick(50 - k);
    btn_n[0] = 1'b1;
    wait_bit(0, 1'b0, k);
    chk("release_latency", 32'(k), 32'd11);
    chk("release_status", status_wire, 32'h0001_0110);
    ack_wire = 32'h8000_0011;
    tick(2);
    chk("ack_clear_all", status_wire, 32'h0000_0000);
    ack_wire = 32'h0;
    tick(1);

    // 3: bounce, 7-cycle pulse, 8-cycle pulse
    for (int j = 0; j < 40; j += 3) begin
      btn_n[1] = ~btn_n[1];
      tick(3);
    end
    btn_n[1] = 1'b1;
    tick(15);
    chk("bounce_ignored", status_wire, 32'h0000_0000);
    btn_n[1] = 1'b0;
    tick(7);
    btn_n[1] = 1'b1;
    tick(15);
    chk("pulse7_ignored", status_wire, 32'h0000_0000);
    btn_n[1] = 1'b0;
    tick(8);
    btn_n[1] = 1'b1;
    tick(25);
    chk("pulse8_accepted", status_wire, 32'h0010_0220);
    ack_wire = 32'h8000_0022;
    tick(2);
    chk("ack_clear_b1", status_wire, 32'h0000_0000);
    ack_wire = 32'h0;
    tick(1);

    // 4: double press sets overflow; ack clears flags, keeps count
    press_release(2);
    press_release(2);
    chk("double_press", status_wire, 32'h0200_4440);
    ack_wire = 32'h0000_0444;
    tick(1);
    ack_wire = 32'h0;
    tick(1);
    chk("ack_444", status_wire, 32'h0200_0000);
    tick(1);

    // 5: held ack does not clear; coincident edge and press: set wins
    ack_wire = 32'h0000_0008;
    tick(3);
    btn_n[3] = 1'b0;
    tick(12);
    chk("held_ack_press", status_wire, 32'h1200_0088);
    btn_n[3] = 1'b1;
    tick(12);
    chk("b3_release", status_wire, 32'h1200_0880);
    ack_wire = 32'h0;
    tick(2);
    btn_n[3] = 1'b0;
    tick(9);
    ack_wire = 32'h0000_0008;
    tick(2);
    chk("set_wins", status_wire, 32'h2200_0888);
    ack_wire = 32'h0;
    btn_n[3] = 1'b1;
    tick(12);
    ack_wire = 32'h8000_0FFF;
    tick(2);
    chk("clear_all_b3", status_wire, 32'h0000_0000);
    ack_wire = 32'h0;
    tick(1);

    // 6: counter wrap, counter clear coincident with press, reset mid-debounce
    for (int j = 0; j < 17; j++) press_release(0);
    chk("count_wrap", status_wire, 32'h0001_1110);
    ack_wire = 32'h0000_0111;
    tick(1);
    ack_wire = 32'h0;
    tick(1);
    chk("flags_cleared", status_wire, 32'h0001_0000);
    btn_n[0] = 1'b0;
    tick(9);
    ack_wire = 32'h8000_0000;
    tick(1);
    ack_wire = 32'h0;
    tick(1);
    chk("clr_and_press", status_wire, 32'h0001_0011);
    btn_n[0] = 1'b1;
    tick(12);
    btn_n[0] = 1'b0;
    tick(5);
    reset    = 1'b1;
    btn_n[0] = 1'b1;
    tick(1);
    chk("reset_mid", status_wire, 32'h0000_0000);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("no_event_after_reset", status_wire, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
